sram_burst_reader: RTL

Burst read engine that sits directly downstream of the single-port SRAM primitive (`Single_Port_SRAM`, DEPTH × DATA_WIDTH). It accepts a command (start address, word count) and issues sequential SRAM reads. It absorbs the SRAM's one-cycle registered-read latency. It delivers the words on a valid/ready stream, with full backpressure support and a sustained throughput of one word per cycle. It is the standard way compute blocks stream weight or activation lines out of on-chip SRAM.

---
 rtl/sram_burst_reader.sv | 106 ++++++++++
 1 files changed

// File: rtl/sram_burst_reader.sv
// Burst read engine for a single-port registered-read SRAM: issues sequential
// reads for a (addr, len) command and streams the words out on valid/ready.
module sram_burst_reader #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [ADDR_WIDTH:0]     cmd_len,
    output logic [ADDR_WIDTH-1:0]   sram_address,
    output logic                    sram_rden,
    output logic                    sram_wren,
    output logic [DATA_WIDTH/8-1:0] sram_byteena,
    input  logic [DATA_WIDTH-1:0]   sram_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH:0]     issue_cnt, deliver_cnt;
    logic                    q_valid;
    logic [DATA_WIDTH-1:0]   fifo_mem [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              fifo_count;
    logic [2:0]              occ_now;
    logic                    accept, pop, issue;

    assign sram_wren    = 1'b0;
    assign sram_byteena = '1;
    assign sram_address = addr;

    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_ready && cmd_valid;
    assign out_valid = (fifo_count != 2'd0) && !rst;
    assign out_data  = fifo_mem[rd_ptr];
    assign out_last  = out_valid && (deliver_cnt == 1);
    assign pop       = out_valid && out_ready;
    assign busy      = (state != IDLE) && !rst;
    assign done      = (state == DONE) && !rst;

    // Words already committed (in FIFO or in flight from the SRAM) minus the
    // one leaving this cycle must leave room for the read issued now.
    assign occ_now   = {1'b0, fifo_count} + {2'b0, q_valid};
    assign issue     = (state == RUN) && (issue_cnt != 0) && !rst
                       && (occ_now < (3'd2 + {2'b0, pop}));
    assign sram_rden = issue;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (cmd_len == 0) ? DONE : RUN;
            RUN:  if (pop && out_last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            issue_cnt   <= '0;
            deliver_cnt <= '0;
            q_valid     <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            q_valid <= issue;
            if (accept) begin
                addr        <= cmd_addr;
                issue_cnt   <= cmd_len;
                deliver_cnt <= cmd_len;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt - 1'b1;
                    addr      <= (addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr + 1'b1;
                end
                if (pop) deliver_cnt <= deliver_cnt - 1'b1;
            end
            if (q_valid) wr_ptr <= ~wr_ptr;
            if (pop)     rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, q_valid} - {1'b0, pop};
        end
    end

    // q is still the previous word on the edge a new read registers, so
    // capturing it here is hazard-free.
    always_ff @(posedge clk) begin
        if (q_valid) fifo_mem[wr_ptr] <= sram_q;
    end
endmodule
